// File: rtl/std_mem_pkg.sv
// rtl/std_mem_pkg.sv - shared types for the std_mem_d1 loader
package std_mem_pkg;

  localparam int LOADER_STATE_BITS = 3;

  typedef enum logic [LOADER_STATE_BITS-1:0] {
    IDLE      = 3'd0,
    WAIT_DATA = 3'd1,
    WRITE     = 3'd2,
    WAIT_DONE = 3'd3,
    FINISH    = 3'd4
  } loader_state_t;

endpackage

// File: rtl/std_mem_d1.sv
// rtl/std_mem_d1.sv - single-port memory with registered write done
module std_mem_d1 #(
  parameter int WIDTH    = 32,
  parameter int SIZE     = 16,
  parameter int IDX_SIZE = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IDX_SIZE-1:0] addr0,
  input  logic [WIDTH-1:0]    write_data,
  input  logic                write_en,
  output logic [WIDTH-1:0]    read_data,
  output logic                done
);

  logic [WIDTH-1:0] mem [SIZE];

  assign read_data = mem[addr0];

  // Storage is not cleared by reset; only the done handshake is.
  always_ff @(posedge clk) begin
    if (write_en) mem[addr0] <= write_data;
  end

  // Done follows a write by one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) done <= 1'b0;
    else       done <= write_en;
  end

endmodule

// File: rtl/std_mem_d1_loader.sv
// rtl/std_mem_d1_loader.sv - streams count words into a std_mem_d1 at addresses 0..count-1
module std_mem_d1_loader
  import std_mem_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int SIZE     = 16,
  parameter int IDX_SIZE = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                go,
  input  logic [IDX_SIZE:0]   count,
  input  logic [WIDTH-1:0]    in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [IDX_SIZE-1:0] mem_addr0,
  output logic [WIDTH-1:0]    mem_write_data,
  output logic                mem_write_en,
  input  logic                mem_done,
  output logic                done
);

  localparam logic [IDX_SIZE:0]   SIZE_W   = (IDX_SIZE+1)'(SIZE);
  localparam logic [IDX_SIZE:0]   CNT_ONE  = (IDX_SIZE+1)'(1);
  localparam logic [IDX_SIZE-1:0] ADDR_ONE = IDX_SIZE'(1);

  loader_state_t     state;
  logic [IDX_SIZE:0] counter;
  logic [IDX_SIZE:0] target;
  logic [IDX_SIZE:0] clamped;
  logic [IDX_SIZE:0] counter_inc;

  // Clamping the request to SIZE keeps the address from ever wrapping.
  assign clamped     = (count > SIZE_W) ? SIZE_W : count;
  assign counter_inc = counter + CNT_ONE;

  // Outputs decode from state alone so an async reset drops them at once.
  assign in_ready     = (state == WAIT_DATA);
  assign mem_write_en = (state == WRITE);
  assign done         = (state == FINISH);

  // Load sequencer: handshake, single-cycle write, wait for memory done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      counter        <= '0;
      target         <= '0;
      mem_addr0      <= '0;
      mem_write_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            target    <= clamped;
            counter   <= '0;
            mem_addr0 <= '0;
            state     <= (clamped == '0) ? FINISH : WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (in_valid) begin
            mem_write_data <= in_data;
            state          <= WRITE;
          end
        end
        WRITE: begin
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (mem_done) begin
            counter <= counter_inc;
            if (counter_inc == target) begin
              state <= FINISH;
            end else begin
              mem_addr0 <= mem_addr0 + ADDR_ONE;
              state     <= WAIT_DATA;
            end
          end
        end
        FINISH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_std_mem_d1_loader.sv
// tb/tb_std_mem_d1_loader.sv - directed bench for std_mem_d1_loader against a real std_mem_d1
module tb_std_mem_d1_loader;
  import std_mem_pkg::*;

  localparam int WIDTH    = 32;
  localparam int SIZE     = 16;
  localparam int IDX_SIZE = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic                go;
  logic [IDX_SIZE:0]   count;
  logic [WIDTH-1:0]    in_data;
  logic                in_valid;
  logic                in_ready;
  logic [IDX_SIZE-1:0] mem_addr0;
  logic [WIDTH-1:0]    mem_write_data;
  logic                mem_write_en;
  logic                mem_done;
  logic                done;
  logic [WIDTH-1:0]    read_data;

  std_mem_d1_loader #(.WIDTH(WIDTH), .SIZE(SIZE), .IDX_SIZE(IDX_SIZE)) dut (
    .clk(clk), .reset(reset), .go(go), .count(count),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_addr0(mem_addr0), .mem_write_data(mem_write_data),
    .mem_write_en(mem_write_en), .mem_done(mem_done), .done(done)
  );

  std_mem_d1 #(.WIDTH(WIDTH), .SIZE(SIZE), .IDX_SIZE(IDX_SIZE)) u_mem (
    .clk(clk), .reset(reset), .addr0(mem_addr0), .write_data(mem_write_data),
    .write_en(mem_write_en), .read_data(read_data), .done(mem_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] we_cyc[$];
  logic [63:0] we_addr[$];
  logic [63:0] we_data[$];
  logic [63:0] done_cyc[$];
  int          hs;
  int          ready_cnt;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] qget(input logic [63:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return '1;
  endfunction

  // Cycle k is the clock period whose closing edge is the k-th after go is sampled.
  task automatic run_load(input int cnt, input int stall_lo, input int stall_hi,
                          input int avail, input int hold_dones, input int budget,
                          input logic [WIDTH-1:0] base);
    we_cyc.delete(); we_addr.delete(); we_data.delete(); done_cyc.delete();
    hs = 0;
    ready_cnt = 0;
    for (int k = 0; k <= budget; k++) begin
      @(negedge clk);
      go       = (k == 0) || (done_cyc.size() < hold_dones);
      count    = (IDX_SIZE+1)'(cnt);
      in_valid = (hs < avail) && !(k >= stall_lo && k <= stall_hi);
      in_data  = base + WIDTH'(hs);
      #1;
      if (in_ready) ready_cnt++;
      if (mem_write_en) begin
        we_cyc.push_back(64'(k));
        we_addr.push_back(64'(mem_addr0));
        we_data.push_back(64'(mem_write_data));
      end
      if (done) done_cyc.push_back(64'(k));
      if (in_ready && in_valid) hs++;
    end
    go       = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    go       = 1'b0;
    count    = '0;
    in_data  = '0;
    in_valid = 1'b0;
    #1;
    check_eq("rst_in_ready", 64'(in_ready), 64'd0);
    check_eq("rst_write_en", 64'(mem_write_en), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_addr", 64'(mem_addr0), 64'd0);
    check_eq("rst_wdata", 64'(mem_write_data), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Basic load of four words.
    run_load(4, -1, -2, 4, 0, 16, 32'hA);
    check_eq("basic_we_count", 64'(we_cyc.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("basic_we_cyc%0d", i), qget(we_cyc, i), 64'(2 + 3 * i));
      check_eq($sformatf("basic_addr%0d", i), qget(we_addr, i), 64'(i));
      check_eq($sformatf("basic_data%0d", i), qget(we_data, i), 64'(32'hA + i));
      check_eq($sformatf("basic_mem%0d", i), 64'(u_mem.mem[i]), 64'(32'hA + i));
    end
    check_eq("basic_done_count", 64'(done_cyc.size()), 64'd1);
    check_eq("basic_done_cyc", qget(done_cyc, 0), 64'd13);

    // Zero count finishes immediately without touching stream or memory.
    run_load(0, -1, -2, 4, 0, 6, 32'h77);
    check_eq("zero_done_count", 64'(done_cyc.size()), 64'd1);
    check_eq("zero_done_cyc", qget(done_cyc, 0), 64'd1);
    check_eq("zero_we_count", 64'(we_cyc.size()), 64'd0);
    check_eq("zero_ready_cnt", 64'(ready_cnt), 64'd0);

    // Stream stall in cycles 1-5: in_ready stays up, then the load resumes.
    run_load(2, 1, 5, 2, 0, 15, 32'h200);
    check_eq("stall_ready_cnt", 64'(ready_cnt), 64'd7);
    check_eq("stall_we_count", 64'(we_cyc.size()), 64'd2);
    check_eq("stall_we_cyc0", qget(we_cyc, 0), 64'd7);
    check_eq("stall_we_cyc1", qget(we_cyc, 1), 64'd10);
    check_eq("stall_data1", qget(we_data, 1), 64'h201);
    check_eq("stall_done_cyc", qget(done_cyc, 0), 64'd12);

    // Count above SIZE is clamped to SIZE.
    run_load(20, -1, -2, 20, 0, 55, 32'h300);
    check_eq("clamp_we_count", 64'(we_cyc.size()), 64'd16);
    check_eq("clamp_first_addr", qget(we_addr, 0), 64'd0);
    check_eq("clamp_last_addr", qget(we_addr, 15), 64'd15);
    check_eq("clamp_handshakes", 64'(hs), 64'd16);
    check_eq("clamp_ready_cnt", 64'(ready_cnt), 64'd16);
    check_eq("clamp_done_count", 64'(done_cyc.size()), 64'd1);
    check_eq("clamp_done_cyc", qget(done_cyc, 0), 64'd49);
    check_eq("clamp_mem15", 64'(u_mem.mem[15]), 64'h30F);

    // Back-to-back: go held across done restarts in the following cycle.
    run_load(1, -1, -2, 2, 2, 12, 32'h400);
    check_eq("b2b_done_count", 64'(done_cyc.size()), 64'd2);
    check_eq("b2b_done0", qget(done_cyc, 0), 64'd4);
    check_eq("b2b_done1", qget(done_cyc, 1), 64'd9);
    check_eq("b2b_we_cyc1", qget(we_cyc, 1), 64'd7);
    check_eq("b2b_addr1", qget(we_addr, 1), 64'd0);
    check_eq("b2b_mem0", 64'(u_mem.mem[0]), 64'h401);

    // Reset in the WAIT_DONE of the third word aborts the load.
    run_load(8, -1, -2, 8, 0, 9, 32'h600);
    check_eq("rstmid_we_count", 64'(we_cyc.size()), 64'd3);
    reset = 1'b1;
    #1;
    check_eq("rstmid_in_ready", 64'(in_ready), 64'd0);
    check_eq("rstmid_write_en", 64'(mem_write_en), 64'd0);
    check_eq("rstmid_done", 64'(done), 64'd0);
    check_eq("rstmid_addr", 64'(mem_addr0), 64'd0);
    check_eq("rstmid_state", 64'(dut.state), 64'(IDLE));
    for (int i = 0; i < 3; i++)
      check_eq($sformatf("rstmid_mem%0d", i), 64'(u_mem.mem[i]), 64'(32'h600 + i));
    check_eq("rstmid_mem3_kept", 64'(u_mem.mem[3]), 64'h303);
    @(negedge clk);
    reset = 1'b0;
    run_load(1, -1, -2, 1, 0, 6, 32'h500);
    check_eq("restart_addr", qget(we_addr, 0), 64'd0);
    check_eq("restart_done_cyc", qget(done_cyc, 0), 64'd4);
    check_eq("restart_mem0", 64'(u_mem.mem[0]), 64'h500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
